// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges nreq requesters onto one FIFO write port.
// It tracks FIFO occupancy with a local credit counter, exposed as level = depth - credits.
module fifo_wr_arbiter #(
  parameter int unsigned nreq  = 4,
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [nreq-1:0]        req,
  input  logic [nreq*width-1:0]  req_data,
  input  logic                   rd_ok,
  input  logic                   fifo_full,
  output logic [nreq-1:0]        gnt,
  output logic                   fifo_wr,
  output logic [width-1:0]       fifo_data,
  output logic [$clog2(depth):0] level,
  output logic                   stall,
  output logic                   err
);

  localparam int unsigned IW = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int unsigned LW = $clog2(depth) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(depth);
  localparam logic [nreq-1:0] ONE_HOT0 = {{(nreq-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [nreq-1:0]   r_gnt;
  logic [nreq-1:0]   w_gnt_nxt;
  logic              r_fifo_wr;
  logic              w_wr_nxt;
  logic [width-1:0]  r_fifo_data;
  logic [width-1:0]  w_data_nxt;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     w_level_nxt;
  logic [IW-1:0]     r_last;
  logic              r_armed;
  logic              r_err;
  logic              w_err_nxt;
  logic [nreq-1:0]   w_elig;
  logic              w_found;
  logic              w_grant;
  logic              w_rd_valid;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_cand;
  logic [width-1:0]  w_words [nreq];

  // Unpack the flat requester data bus into one word per slot.
  for (genvar g = 0; g < int'(nreq); g++) begin : g_words
    assign w_words[g] = req_data[g*width +: width];
  end

  // Winner search, grant decision, credit and error next-state.
  always_comb begin
    w_elig      = req & ~r_gnt;
    w_found     = 1'b0;
    w_win       = '0;
    w_cand      = '0;
    for (int k = 1; k <= int'(nreq); k++) begin
      w_cand = IW'((int'(r_last) + k) % int'(nreq));
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end

    // r_armed holds off grants for the first edge after reset release.
    w_grant     = w_found && r_armed && (r_level != FULL_LVL);
    w_state_nxt = S_IDLE;
    w_gnt_nxt   = '0;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = '0;
    if (w_found && r_armed) begin
      if (w_grant) begin
        w_state_nxt = S_GRANT;
        w_gnt_nxt   = ONE_HOT0 << w_win;
        w_wr_nxt    = 1'b1;
        w_data_nxt  = w_words[w_win];
      end else begin
        w_state_nxt = S_STALL;
      end
    end

    // A read at level 0 is an underflow: flagged, and ignored by the counter.
    w_rd_valid  = rd_ok && (r_level != '0);
    w_level_nxt = r_level;
    if (w_grant && !w_rd_valid) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_grant && w_rd_valid) begin
      w_level_nxt = r_level - LW'(1);
    end

    w_err_nxt = r_err | (r_fifo_wr & fifo_full) | (rd_ok & (r_level == '0));
  end

  // State, outputs and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_level     <= '0;
      r_last      <= IW'(nreq - 1);
      r_armed     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_fifo_wr   <= w_wr_nxt;
      r_fifo_data <= w_data_nxt;
      r_level     <= w_level_nxt;
      r_armed     <= 1'b1;
      r_err       <= w_err_nxt;
      if (w_grant) begin
        r_last <= w_win;
      end
    end
  end

  assign gnt       = r_gnt;
  assign fifo_wr   = r_fifo_wr;
  assign fifo_data = r_fifo_data;
  assign level     = r_level;
  assign stall     = (r_state == S_STALL);
  assign err       = r_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with default parameters.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        rd_ok;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [3:0]  level;
  logic        stall;
  logic        err;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .rd_ok     (rd_ok),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .level     (level),
    .stall     (stall),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    rd_ok     = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_stall(input string name, input int budget);
    int n = 0;
    while (stall !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(stall), 32'd1);
  endtask

  // Monitor: every written word must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got gnt=%b data=%h, required no write (t=%0t)", gnt, fifo_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_onehot", 32'(gnt), 32'(mon_e.gnt));
          check("write_data", 32'(fifo_data), 32'(mon_e.data));
        end
      end else begin
        check("idle_gnt_zero", 32'(gnt), 32'd0);
        check("idle_data_zero", 32'(fifo_data), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int ngr;
    int cyc;
    int last_cyc;
    bit got;

    req_data = '0;
    // Reset values, before any clock edge.
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_fifo_wr", 32'(fifo_wr), 0);
    check("rst_fifo_data", 32'(fifo_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_err", 32'(err), 0);

    // Round robin, all four requesting.
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) push(4'b0001 << (k % 4), 8'hA0 + 8'(k % 4));
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first_edge_no_grant", 32'(fifo_wr), 0);
    @(negedge clk);
    check("second_edge_grant", 32'(fifo_wr), 1);
    wait_stall("rr_stall", 20);
    check("rr_level_full", 32'(level), 8);
    repeat (4) @(negedge clk);
    check("rr_stall_held", 32'(stall), 1);
    check("rr_queue_drained", 32'(exp_q.size()), 0);

    // Credit return from stall: level 7 at c+1, grant at c+2, stall at c+3.
    push(4'b0001, 8'hA0);
    @(posedge clk); #1 rd_ok = 1'b1;
    @(posedge clk); #1 rd_ok = 1'b0;
    @(negedge clk);
    check("cr_level_c1", 32'(level), 7);
    check("cr_no_wr_c1", 32'(fifo_wr), 0);
    check("cr_stall_c1", 32'(stall), 1);
    @(negedge clk);
    check("cr_wr_c2", 32'(fifo_wr), 1);
    check("cr_level_c2", 32'(level), 8);
    @(negedge clk);
    check("cr_stall_c3", 32'(stall), 1);
    check("cr_queue_drained", 32'(exp_q.size()), 0);

    // Grant and read in the same cycle keep level steady.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 11; k++) push(4'b0001 << (k % 4), 8'hA0 + 8'(k % 4));
    rst_n = 1'b1;
    n = 0;
    while (level !== 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("sim_reach_level5", 32'(level), 5);
    rd_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sim_level_steady", 32'(level), 5);
      check("sim_wr_active", 32'(fifo_wr), 1);
    end
    rd_ok = 1'b0;
    wait_stall("sim_stall", 20);
    check("sim_level_full", 32'(level), 8);
    check("sim_queue_drained", 32'(exp_q.size()), 0);

    // Single requester: grants every other cycle until full.
    do_reset();
    req_data[2*8 +: 8] = 8'h5A;
    req = 4'b0100;
    for (int k = 0; k < 8; k++) push(4'b0100, 8'h5A);
    rst_n = 1'b1;
    ngr = 0;
    last_cyc = 0;
    for (cyc = 0; cyc < 40 && ngr < 8; cyc++) begin
      @(negedge clk);
      if (fifo_wr === 1'b1) begin
        if (ngr > 0) check("mask_spacing", 32'(cyc - last_cyc), 2);
        last_cyc = cyc;
        ngr++;
      end
    end
    check("single_grant_count", 32'(ngr), 8);
    check("single_level_full", 32'(level), 8);
    wait_stall("single_stall", 10);
    check("single_queue_drained", 32'(exp_q.size()), 0);

    // Overflow: fifo_full during a write sets a sticky err.
    do_reset();
    req_data[7:0] = 8'h11;
    req = 4'b0001;
    push(4'b0001, 8'h11);
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fifo_wr === 1'b1) got = 1'b1;
    end
    check("ovf_saw_write", 32'(got), 1);
    check("ovf_err_before", 32'(err), 0);
    fifo_full = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1 fifo_full = 1'b0;
    @(negedge clk);
    check("ovf_err_set", 32'(err), 1);
    repeat (5) @(negedge clk);
    check("ovf_err_held", 32'(err), 1);

    // Underflow: rd_ok at level 0.
    do_reset();
    check("udf_err_cleared", 32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1 rd_ok = 1'b1;
    @(posedge clk); #1 rd_ok = 1'b0;
    @(negedge clk);
    check("udf_err_set", 32'(err), 1);
    check("udf_level_zero", 32'(level), 0);

    // Asynchronous reset while gnt=0100 is showing.
    req_data[2*8 +: 8] = 8'h5A;
    req = 4'b0100;
    push(4'b0100, 8'h5A);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt === 4'b0100) got = 1'b1;
    end
    check("ar_saw_grant", 32'(got), 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_fifo_wr", 32'(fifo_wr), 0);
    check("ar_fifo_data", 32'(fifo_data), 0);
    check("ar_level", 32'(level), 0);
    check("ar_err", 32'(err), 0);
    check("ar_stall", 32'(stall), 0);
    check("ar_queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
